lut_sweep_checker: RTL and testbench

Synthesizable successor to our exhaustive truth-table testbenches. It drives every input combination of an N-input combinational DUT in ascending order. After a programmable settle time it samples the DUT output and compares it with an expected truth table (LUT) loaded at start. It reports pass/fail, an error count and the first failing index, and sits beside any combinational block under test, on-chip or in simulation.

---
 rtl/lut_sweep_checker_pkg.sv | 21 ++
 rtl/lut_sweep_checker_settle_timer.sv | 32 +++
 rtl/lut_sweep_checker.sv | 114 +++++++++++
 tb/tb_lut_sweep_checker.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_sweep_checker_pkg.sv
// Shared types and constants for the exhaustive LUT sweep checker.
package lut_sweep_checker_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Number of truth-table entries for an n-input block
  function automatic int lut_width(input int n_in);
    return 1 << n_in;
  endfunction

  // Truth table of the block currently under test:
  // F = AC + ABC' + BD + A'C'D', index {A,B,C,D}, A is the MSB
  localparam int          DUT_N_IN    = 4;
  localparam logic [15:0] DUT_DEF_LUT = 16'hFCB1;

endpackage

// File: rtl/lut_sweep_checker_settle_timer.sv
// Hold-time counter: counts the cycles a vector has been presented and
// flags the cycle on which the block-under-test output may be sampled.
module settle_timer
  import lut_sweep_checker_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  logic [CW-1:0] cnt;

  // With SETTLE=0 the counter stays at zero and tick is permanently high
  assign tick = (cnt == CW'(SETTLE));

  // Count up while enabled, restart after each sample or on an accepted start
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lut_sweep_checker.sv
// Exhaustive truth-table sweeper: walks every input vector in ascending
// order, samples the block output after a settle time and scores it
// against an expected LUT latched at start.
module lut_sweep_checker
  import lut_sweep_checker_pkg::*;
#(
  parameter int                            N_IN    = DUT_N_IN,
  parameter int                            SETTLE  = 2,
  parameter logic [lut_width(N_IN)-1:0]    DEF_LUT = DUT_DEF_LUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop_on_err,
  input  logic [lut_width(N_IN)-1:0] lut_cfg,
  output logic [N_IN-1:0]            vec_o,
  input  logic                       dut_f_i,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_IN:0]              err_cnt,
  output logic                       first_err_vld,
  output logic [N_IN-1:0]            first_err_idx
);

  localparam int              LW       = lut_width(N_IN);
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN:0]   ERR_MAX  = (N_IN + 1)'(LW);

  state_t          state;
  logic [LW-1:0]   lut;
  logic            stop_lat;
  logic            tick;
  logic            timer_clear;
  logic            timer_en;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // A start is only accepted outside a sweep; it also restarts the hold timer
  assign timer_clear = (state != APPLY) && start;
  assign timer_en    = (state == APPLY);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (timer_clear),
    .en    (timer_en),
    .tick  (tick)
  );

  // Score of the current sample, including the saturating error count it implies
  always_comb begin
    mismatch = (dut_f_i != lut[vec_o]);
    err_next = err_cnt;
    if (mismatch && (err_cnt != ERR_MAX)) err_next = err_cnt + 1'b1;
  end

  // Sweep FSM, vector counter and scoreboard with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      lut           <= DEF_LUT;
      stop_lat      <= 1'b0;
      vec_o         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_cnt       <= '0;
      first_err_vld <= 1'b0;
      first_err_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            lut           <= lut_cfg;
            stop_lat      <= stop_on_err;
            vec_o         <= '0;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
            state         <= APPLY;
          end
        end
        APPLY: begin
          if (tick) begin
            err_cnt <= err_next;
            if (mismatch && !first_err_vld) begin
              first_err_vld <= 1'b1;
              first_err_idx <= vec_o;
            end
            if ((vec_o == VEC_LAST) || (mismatch && stop_lat)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == '0);
              state <= DONE;
            end else begin
              vec_o <= vec_o + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lut_sweep_checker.sv
// Self-checking bench for lut_sweep_checker: a transaction-level reference
// model tracks every cycle, and hand-derived results pin the key scenarios.
module tb_lut_sweep_checker;

  localparam int N_IN   = 4;
  localparam int SETTLE = 2;
  localparam int NVEC   = 1 << N_IN;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop_on_err;
  logic [15:0] lut_cfg;
  logic [3:0]  vec_o;
  logic        dut_f_i;
  logic        busy, done, pass, first_err_vld;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_idx;

  // Second instance built with SETTLE=0, fed by a correct block model
  logic        start0;
  logic [3:0]  vec0;
  logic        f0;
  logic        busy0, done0, pass0, fv0;
  logic [4:0]  err0;
  logic [3:0]  fi0;

  int n_cmp = 0;
  int n_err = 0;
  int f_mode = 0;
  bit chk_en = 1'b0;

  // Reference model state
  bit          m_busy, m_done, m_pass, m_fv, m_stop;
  int          m_vec, m_err, m_fi, m_phase;
  logic [15:0] m_lut;

  always #5 clk = ~clk;

  lut_sweep_checker #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .stop_on_err(stop_on_err),
    .lut_cfg(lut_cfg), .vec_o(vec_o), .dut_f_i(dut_f_i), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_vld(first_err_vld), .first_err_idx(first_err_idx)
  );

  lut_sweep_checker #(.N_IN(N_IN), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop_on_err(1'b0),
    .lut_cfg(16'hFCB1), .vec_o(vec0), .dut_f_i(f0), .busy(busy0),
    .done(done0), .pass(pass0), .err_cnt(err0),
    .first_err_vld(fv0), .first_err_idx(fi0)
  );

  function automatic logic ref_f(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (a & c) | (a & b & ~c) | (b & d) | (~a & ~c & ~d);
  endfunction

  assign f0 = ref_f(vec0);

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Block-under-test output: correct, stuck-at-0, stuck-at-1 or random
  always @(negedge clk) begin
    case (f_mode)
      0:       dut_f_i = ref_f(vec_o);
      1:       dut_f_i = 1'b0;
      2:       dut_f_i = 1'b1;
      default: dut_f_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model: one vector per SETTLE+1 edges, scored on the last edge
  always @(posedge clk) begin
    bit mis;
    if (rst) begin
      m_busy = 0; m_done = 0; m_pass = 0; m_fv = 0;
      m_vec = 0; m_err = 0; m_fi = 0; m_phase = 0;
    end else if (!m_busy && start) begin
      m_lut = lut_cfg; m_stop = stop_on_err;
      m_busy = 1; m_done = 0; m_pass = 0; m_fv = 0;
      m_vec = 0; m_err = 0; m_fi = 0; m_phase = 0;
    end else if (m_busy) begin
      if (m_phase < SETTLE) begin
        m_phase++;
      end else begin
        mis = (dut_f_i !== m_lut[m_vec]);
        if (mis) begin
          if (m_err < NVEC) m_err++;
          if (!m_fv) begin m_fv = 1; m_fi = m_vec; end
        end
        if (m_vec == NVEC - 1 || (mis && m_stop)) begin
          m_busy = 0; m_done = 1; m_pass = (m_err == 0);
        end else begin
          m_vec++;
          m_phase = 0;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("busy", busy, m_busy);
      checkOutput("done", done, m_done);
      checkOutput("pass", pass, m_pass);
      checkOutput("vec_o", vec_o, m_vec);
      checkOutput("err_cnt", err_cnt, m_err);
      checkOutput("first_err_vld", first_err_vld, m_fv);
      checkOutput("first_err_idx", first_err_idx, m_fi);
    end
  end

  // One sweep: measure edges from the start edge until done is seen
  task automatic applyStimulus(input bit stop, input logic [15:0] cfg,
                               input int mode, input bit disturb,
                               output int lat);
    f_mode      = mode;
    lut_cfg     = cfg;
    stop_on_err = stop;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
      if (disturb && lat == 10) begin
        start = 1'b1; lut_cfg = 16'h0000; stop_on_err = 1'b1;
      end
      if (disturb && lat == 11) start = 1'b0;
    end
    checkOutput("sweep_done", done, 1);
  endtask

  initial begin
    int lat;
    rst = 1'b1; start = 1'b0; start0 = 1'b0; stop_on_err = 1'b0;
    lut_cfg = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] clean sweep");
    applyStimulus(1'b0, 16'hFCB1, 0, 1'b0, lat);
    checkOutput("clean_lat", lat, 48);
    checkOutput("clean_pass", pass, 1);
    checkOutput("clean_err", err_cnt, 0);
    checkOutput("clean_fv", first_err_vld, 0);
    checkOutput("clean_vec", vec_o, 15);

    $display("[TB] stuck at 0");
    applyStimulus(1'b0, 16'hFCB1, 1, 1'b0, lat);
    checkOutput("s0_lat", lat, 48);
    checkOutput("s0_err", err_cnt, 10);
    checkOutput("s0_idx", first_err_idx, 0);
    checkOutput("s0_pass", pass, 0);

    $display("[TB] stuck at 1");
    applyStimulus(1'b0, 16'hFCB1, 2, 1'b0, lat);
    checkOutput("s1_err", err_cnt, 6);
    checkOutput("s1_idx", first_err_idx, 1);
    checkOutput("s1_pass", pass, 0);

    $display("[TB] stuck at 0 with stop_on_err");
    applyStimulus(1'b1, 16'hFCB1, 1, 1'b0, lat);
    checkOutput("stop_lat", lat, 3);
    checkOutput("stop_err", err_cnt, 1);
    checkOutput("stop_idx", first_err_idx, 0);
    checkOutput("stop_vec", vec_o, 0);

    $display("[TB] reset mid-sweep");
    f_mode = 1; lut_cfg = 16'hFCB1; stop_on_err = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_done", done, 0);
    checkOutput("mrst_vec", vec_o, 0);
    checkOutput("mrst_err", err_cnt, 0);
    checkOutput("mrst_fv", first_err_vld, 0);
    @(negedge clk); rst = 1'b0;
    applyStimulus(1'b0, 16'hFCB1, 0, 1'b0, lat);
    checkOutput("after_rst_lat", lat, 48);
    checkOutput("after_rst_pass", pass, 1);

    $display("[TB] reset and start together");
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_start_busy", busy, 0);
    @(negedge clk); rst = 1'b0; start = 1'b0;

    $display("[TB] start and lut_cfg disturbed mid-sweep");
    applyStimulus(1'b0, 16'hFCB1, 0, 1'b1, lat);
    checkOutput("dist_lat", lat, 48);
    checkOutput("dist_pass", pass, 1);
    checkOutput("dist_err", err_cnt, 0);

    $display("[TB] randomized sweeps");
    for (int r = 0; r < 6; r++) begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 3, 1'b0, lat);
    end

    $display("[TB] SETTLE=0 instance");
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start0 = 1'b0;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done0) break;
    end
    checkOutput("s0build_done", done0, 1);
    checkOutput("s0build_lat", lat, 16);
    checkOutput("s0build_pass", pass0, 1);
    checkOutput("s0build_err", err0, 0);
    checkOutput("s0build_fv", fv0, 0);
    checkOutput("s0build_vec", vec0, 15);
    checkOutput("s0build_busy", busy0, 0);
    checkOutput("s0build_idx", fi0, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
